multicycle_controller: RTL and testbench

Control unit for the multicycle RV32I datapath: a Moore main FSM sequences each instruction through fetch, decode, execute, memory and writeback. A combinational ALU decoder drives the `ALUControl` code consumed by the datapath ALU. It sits beside the datapath, taking the instruction fields from the instruction register and the ALU `Zero` flag. It returns every mux select and write enable.

---
 rtl/multicycle_controller_pkg.sv | 101 ++++++++++
 rtl/multicycle_controller_alu_decoder.sv | 32 +++
 rtl/multicycle_controller.sv | 101 ++++++++++
 tb/tb_multicycle_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, ALU codes,
// FSM states and the per-state control word.
package multicycle_controller_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecuteR,
        StExecuteI,
        StAluWb,
        StBeq,
        StJal
    } ctrl_state_t;

    typedef struct packed {
        logic       pcupdate;
        logic       branch;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
    } ctrl_t;

    // Moore control word for a state; unlisted fields stay zero.
    function automatic ctrl_t state_ctrl(input ctrl_state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            StDecode: begin
                c.alusrca = 2'b01;
                c.alusrcb = 2'b01;
            end
            StMemAdr: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
            end
            StMemRead: c.adrsrc = 1'b1;
            StMemWrite: begin
                c.adrsrc   = 1'b1;
                c.memwrite = 1'b1;
            end
            StMemWb: begin
                c.resultsrc = 2'b01;
                c.regwrite  = 1'b1;
            end
            StExecuteR: begin
                c.alusrca = 2'b10;
                c.aluop   = ALUOP_FUNCT;
            end
            StExecuteI: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
                c.aluop   = ALUOP_FUNCT;
            end
            StAluWb: c.regwrite = 1'b1;
            StBeq: begin
                c.alusrca = 2'b10;
                c.aluop   = ALUOP_SUB;
                c.branch  = 1'b1;
            end
            StJal: begin
                c.alusrca  = 2'b01;
                c.alusrcb  = 2'b10;
                c.pcupdate = 1'b1;
            end
            default: begin
                c.irwrite   = 1'b1;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
                c.pcupdate  = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus instruction fields to the ALU
// operation code.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type with funct7b5 set is sub; addi ignores bit 30.
                    3'b000:  ALUControl = ({op5, funct7b5} == 2'b11) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I datapath, with registered
// per-state control word, ImmSrc decode and ALU decoder.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic       IllegalOp
);

    ctrl_state_t state_q, state_d;
    ctrl_t       ctrl_q;
    logic        op_legal;

    always_comb begin
        op_legal = 1'b1;
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: op_legal = 1'b1;
            default:                                  op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (op)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_R:         state_d = StExecuteR;
                    OP_I:         state_d = StExecuteI;
                    OP_BEQ:       state_d = StBeq;
                    OP_JAL:       state_d = StJal;
                    default:      state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = (op == OP_SW) ? StMemWrite : StMemRead;
            StMemRead:  state_d = StMemWb;
            StExecuteR: state_d = StAluWb;
            StExecuteI: state_d = StAluWb;
            StJal:      state_d = StAluWb;
            default:    state_d = StFetch;
        endcase
    end

    // Control word is registered alongside the state so it is glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFetch;
            ctrl_q  <= state_ctrl(StFetch);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d);
        end
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    alu_decoder u_alu_decoder (
        .ALUOp      (ctrl_q.aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .ALUControl (ALUControl)
    );

    // Enables are gated by reset so nothing fires while reset is held, yet
    // FETCH enables are live the moment reset is released.
    assign PCWrite   = reset_n & (ctrl_q.pcupdate | (ctrl_q.branch & Zero));
    assign IRWrite   = reset_n & ctrl_q.irwrite;
    assign MemWrite  = reset_n & ctrl_q.memwrite;
    assign RegWrite  = reset_n & ctrl_q.regwrite;
    assign IllegalOp = reset_n & (state_q == StDecode) & ~op_legal;
    assign AdrSrc    = ctrl_q.adrsrc;
    assign ResultSrc = ctrl_q.resultsrc;
    assign ALUSrcA   = ctrl_q.alusrca;
    assign ALUSrcB   = ctrl_q.alusrcb;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: driver pushes per-cycle expected
// control vectors, a monitor pops and compares them.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    multicycle_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .ALUControl (ALUControl),
        .IllegalOp  (IllegalOp)
    );

    always #5 clk = ~clk;

    localparam int S_RST      = 0;
    localparam int S_FETCH    = 1;
    localparam int S_DECODE   = 2;
    localparam int S_MEMADR   = 3;
    localparam int S_MEMREAD  = 4;
    localparam int S_MEMWB    = 5;
    localparam int S_MEMWRITE = 6;
    localparam int S_EXECR    = 7;
    localparam int S_EXECI    = 8;
    localparam int S_ALUWB    = 9;
    localparam int S_BEQ      = 10;
    localparam int S_JAL      = 11;

    logic [16:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          passed = 0;
    logic [1:0]  cur_imm;
    event        sample_now;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,RegWrite,ALUControl,IllegalOp}
    function automatic logic [16:0] exp_vec(input int st, input logic [2:0] exec_alu,
                                            input logic [1:0] imm, input logic z,
                                            input logic ill);
        logic pcw, adr, mw, irw, rw, il;
        logic [1:0] rs, a, b;
        logic [2:0] alu;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; il = 0;
        rs = 2'b00; a = 2'b00; b = 2'b00; alu = 3'b000;
        case (st)
            S_RST:      begin rs = 2'b10; b = 2'b10; end
            S_FETCH:    begin irw = 1; pcw = 1; b = 2'b10; rs = 2'b10; end
            S_DECODE:   begin a = 2'b01; b = 2'b01; il = ill; end
            S_MEMADR:   begin a = 2'b10; b = 2'b01; end
            S_MEMREAD:  adr = 1;
            S_MEMWRITE: begin adr = 1; mw = 1; end
            S_MEMWB:    begin rs = 2'b01; rw = 1; end
            S_EXECR:    begin a = 2'b10; alu = exec_alu; end
            S_EXECI:    begin a = 2'b10; b = 2'b01; alu = exec_alu; end
            S_ALUWB:    rw = 1;
            S_BEQ:      begin a = 2'b10; alu = 3'b001; pcw = z; end
            S_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
            default:    ;
        endcase
        return {pcw, adr, mw, irw, rs, a, b, imm, rw, alu, il};
    endfunction

    task automatic push(input int st, input string nm, input logic [2:0] ea, input logic ill);
        exp_q.push_back(exp_vec(st, ea, cur_imm, Zero, ill));
        name_q.push_back(nm);
    endtask

    task automatic step(input int st, input string nm, input logic [2:0] ea, input logic ill);
        push(st, nm, ea, ill);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic [1:0] imm);
        op = o;
        funct3 = f3;
        funct7b5 = f7;
        cur_imm = imm;
    endtask

    task automatic run_rtype(input logic [2:0] f3, input logic f7, input logic [2:0] ea,
                             input string nm);
        set_instr(7'b0110011, f3, f7, 2'b00);
        step(S_FETCH, {nm, "_fetch"}, 3'b000, 1'b0);
        step(S_DECODE, {nm, "_decode"}, 3'b000, 1'b0);
        step(S_EXECR, {nm, "_exec"}, ea, 1'b0);
        step(S_ALUWB, {nm, "_wb"}, 3'b000, 1'b0);
    endtask

    task automatic run_itype(input logic [2:0] f3, input logic f7, input logic [2:0] ea,
                             input string nm);
        set_instr(7'b0010011, f3, f7, 2'b00);
        step(S_FETCH, {nm, "_fetch"}, 3'b000, 1'b0);
        step(S_DECODE, {nm, "_decode"}, 3'b000, 1'b0);
        step(S_EXECI, {nm, "_exec"}, ea, 1'b0);
        step(S_ALUWB, {nm, "_wb"}, 3'b000, 1'b0);
    endtask

    task automatic run_beq(input logic z, input string nm);
        set_instr(7'b1100011, 3'b000, 1'b0, 2'b10);
        Zero = 1'b1;
        step(S_FETCH, {nm, "_fetch"}, 3'b000, 1'b0);
        step(S_DECODE, {nm, "_decode"}, 3'b000, 1'b0);
        Zero = z;
        step(S_BEQ, {nm, "_beq"}, 3'b000, 1'b0);
        Zero = 1'b0;
    endtask

    // Monitor: compares the oldest expectation at each sample point.
    initial begin
        logic [16:0] got, e;
        string       n;
        forever begin
            @(negedge clk or sample_now);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                       ImmSrc, RegWrite, ALUControl, IllegalOp};
                checks++;
                if (got === e) passed++;
                else $display("FAIL %s: got %b expected %b", n, got, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, checks=%0d passed=%0d", checks, passed);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        Zero = 1'b0;
        set_instr(7'b0000011, 3'b010, 1'b0, 2'b00);
        @(posedge clk);
        #1;
        step(S_RST, "reset_hold0", 3'b000, 1'b0);
        step(S_RST, "reset_hold1", 3'b000, 1'b0);
        reset_n = 1'b1;

        step(S_FETCH, "lw_fetch", 3'b000, 1'b0);
        step(S_DECODE, "lw_decode", 3'b000, 1'b0);
        step(S_MEMADR, "lw_memadr", 3'b000, 1'b0);
        step(S_MEMREAD, "lw_memread", 3'b000, 1'b0);
        step(S_MEMWB, "lw_memwb", 3'b000, 1'b0);

        set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
        step(S_FETCH, "sw_fetch", 3'b000, 1'b0);
        step(S_DECODE, "sw_decode", 3'b000, 1'b0);
        step(S_MEMADR, "sw_memadr", 3'b000, 1'b0);
        step(S_MEMWRITE, "sw_memwrite", 3'b000, 1'b0);

        run_rtype(3'b000, 1'b1, 3'b001, "sub");
        run_rtype(3'b010, 1'b0, 3'b101, "slt");
        run_rtype(3'b110, 1'b0, 3'b011, "or");
        run_rtype(3'b000, 1'b0, 3'b000, "add");
        run_itype(3'b000, 1'b1, 3'b000, "addi");
        run_itype(3'b111, 1'b0, 3'b010, "andi");

        run_beq(1'b1, "beq_taken");
        run_beq(1'b0, "beq_nottaken");

        set_instr(7'b1101111, 3'b000, 1'b0, 2'b11);
        step(S_FETCH, "jal_fetch", 3'b000, 1'b0);
        step(S_DECODE, "jal_decode", 3'b000, 1'b0);
        step(S_JAL, "jal_jal", 3'b000, 1'b0);
        step(S_ALUWB, "jal_wb", 3'b000, 1'b0);

        set_instr(7'b1111111, 3'b000, 1'b0, 2'b00);
        step(S_FETCH, "ill_fetch", 3'b000, 1'b0);
        step(S_DECODE, "ill_decode", 3'b000, 1'b1);
        step(S_FETCH, "ill_back_fetch", 3'b000, 1'b0);

        // Reset asserted mid-MEMWRITE, sampled before the next clock edge.
        set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
        step(S_DECODE, "rst_sw_decode", 3'b000, 1'b0);
        step(S_MEMADR, "rst_sw_memadr", 3'b000, 1'b0);
        push(S_MEMWRITE, "rst_sw_memwrite", 3'b000, 1'b0);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        push(S_RST, "rst_async_drop", 3'b000, 1'b0);
        #2;
        ->sample_now;
        @(posedge clk);
        #1;
        push(S_RST, "rst_held", 3'b000, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(S_FETCH, "rst_rel_fetch", 3'b000, 1'b0);
        step(S_DECODE, "rst_rel_decode", 3'b000, 1'b0);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
